rr_mux_reg_nway: RTL and testbench

- Parametrised successor to the fixed 2/4/8-way 32-bit selectors in the execution core.
- Selects one of N valid/ready source channels of WIDTH bits each, using round-robin arbitration.
- Registers the winner into a single output stage with a valid/ready handshake.
- Used wherever multiple producers share one downstream port, e.g. writeback results or bus requests.

---
 rtl/basic_pkg.sv | 22 ++
 rtl/rr_pick_nway.sv | 54 +++++
 rtl/rr_mux_reg_nway.sv | 141 ++++++++++++++
 tb/tb_rr_mux_reg_nway.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/basic_pkg.sv
// Shared arbitration helpers: grant index width calculation, the largest
// supported arbiter size and a full-width one-hot grant vector type.
package basic_pkg;

    localparam int MAX_ARB_N = 16;

    // One-hot grant vector sized for the largest supported arbiter.
    typedef logic [MAX_ARB_N-1:0] arb_onehot_t;

    // Ceiling log2, never less than 1 so a 2-way index still has one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick_nway.sv
// Round-robin pick: finds the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational.
// The request vector is doubled and rotated right by ptr, then priority-encoded.
module rr_pick_nway import basic_pkg::*; #(
    parameter int N = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]     req_rot;
    logic [SEL_W-1:0] offset;
    logic [SEL_W:0]   idx_sum;

    // Bit j of req_rot is request (ptr + j) mod N; ptr is always below N.
    assign req_rot = N'({req, req} >> ptr);
    assign any_gnt = |req_rot;

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    // Undo the rotation: absolute index is ptr + offset, folded back below N.
    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= N_EXT) begin
            idx_sum = idx_sum - N_EXT;
        end
    end

    assign gnt_idx = idx_sum[SEL_W-1:0];

    // Expand the winning index to one-hot; all-zero when nobody requests.
    always_comb begin
        gnt_onehot = '0;
        if (any_gnt) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_reg_nway.sv
// N-way round-robin valid/ready selector with a single registered output stage.
// Optional macro MUX_ARB_LOCK_EN: a source may hold the grant across beats
// by raising in_lock; without it in_lock is ignored.
module rr_mux_reg_nway import basic_pkg::*; #(
    parameter int N = 4,
    parameter int WIDTH = 32,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_lock,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt_onehot;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] ptr_after_gnt;
    logic             any_gnt;
    logic             load_ok;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    // The output register can take a new beat when empty or draining this cycle.
    assign load_ok = ~out_valid | out_ready;

`ifdef MUX_ARB_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    logic [N-1:0]     lock_mask;

    // While locked only the owning channel may compete for the grant.
    always_comb begin
        lock_mask = '1;
        if (locked) begin
            lock_mask = '0;
            lock_mask[lock_ch] = 1'b1;
        end
    end

    assign req = in_valid & lock_mask;
`else
    logic unused_lock;

    assign unused_lock = ^in_lock;
    assign req = in_valid;
`endif

    rr_pick_nway #(
        .N (N)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    assign in_ready = load_ok ? gnt_onehot : '0;
    assign accept   = load_ok & any_gnt;

    // Channel after the winner, wrapping from N-1 to 0 for any N.
    assign ptr_after_gnt = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);

    // One-hot AND-OR data select across all channels.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_onehot[i]}});
        end
    end

    // Output valid and source index: load on free slot, hold on stall.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
        end else if (load_ok) begin
            out_valid <= any_gnt;
            if (any_gnt) begin
                out_sel <= gnt_idx;
            end
        end
    end

    // Output data: one enable-muxed flop per bit, loaded only on accept.
    for (genvar b = 0; b < WIDTH; b++) begin : g_data_bit
        logic q;

        always_ff @(posedge clk) begin
            if (reset) begin
                q <= 1'b0;
            end else if (accept) begin
                q <= mux_data[b];
            end
        end

        assign out_data[b] = q;
    end

`ifdef MUX_ARB_LOCK_EN
    // Priority pointer and lock state; ptr is frozen for a whole locked sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            if (locked) begin
                if (!in_lock[lock_ch]) begin
                    locked <= 1'b0;
                    ptr    <= ptr_after_gnt;
                end
            end else if (in_lock[gnt_idx]) begin
                locked  <= 1'b1;
                lock_ch <= gnt_idx;
            end else begin
                ptr <= ptr_after_gnt;
            end
        end
    end
`else
    // Priority pointer: the channel after each winner becomes highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_after_gnt;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_reg_nway.sv
// Self-checking bench for rr_mux_reg_nway: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural round-robin model. A second small instance covers N=3.
module tb_rr_mux_reg_nway;

    localparam int N = 4;
    localparam int WIDTH = 32;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_lock;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    // Three-way instance for the non-power-of-two wrap.
    logic               reset3;
    logic [2:0]         v3;
    logic [23:0]        d3;
    logic [2:0]         rdy3;
    logic               ov3;
    logic [7:0]         od3;
    logic [1:0]         os3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_mux_reg_nway #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_lock   (in_lock),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_mux_reg_nway #(.N(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .in_valid  (v3),
        .in_data   (d3),
        .in_lock   (3'b000),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_sel   (os3),
        .out_ready (1'b1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    bit               m_init = 0;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_sel;
    int               m_ptr;
    bit               m_locked;
    int               m_lock_ch;

    // Walk channels ptr, ptr+1, ... modulo N; first eligible valid one wins.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int j = 0; j < N; j++) begin
            int c;
            c = (m_ptr + j) % N;
            if (v[c] && (!m_locked || c == m_lock_ch)) begin
                return c;
            end
        end
        return -1;
    endfunction

    // Compare at the falling edge, then advance the model to the next rising edge.
    initial begin
        int g;
        bit load_ok;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (m_init) begin
                g = model_pick(in_valid);
                load_ok = !m_valid || out_ready;
                exp_rdy = '0;
                if (load_ok && g >= 0) exp_rdy[g] = 1'b1;
                check("cyc_in_ready", in_ready, exp_rdy);
                check("cyc_out_valid", out_valid, m_valid);
                if (m_valid) begin
                    check("cyc_out_data", out_data, m_data);
                    check("cyc_out_sel", out_sel, m_sel);
                end
            end
            if (reset) begin
                m_init    = 1;
                m_valid   = 1'b0;
                m_data    = '0;
                m_sel     = 0;
                m_ptr     = 0;
                m_locked  = 0;
                m_lock_ch = 0;
            end else if (m_init) begin
                g = model_pick(in_valid);
                load_ok = !m_valid || out_ready;
                if (load_ok) begin
                    if (g >= 0) begin
                        m_valid = 1'b1;
                        m_data  = in_data[g*WIDTH +: WIDTH];
                        m_sel   = g;
`ifdef MUX_ARB_LOCK_EN
                        if (m_locked) begin
                            if (!in_lock[g]) begin
                                m_locked = 0;
                                m_ptr = (g + 1) % N;
                            end
                        end else if (in_lock[g]) begin
                            m_locked  = 1;
                            m_lock_ch = g;
                        end else begin
                            m_ptr = (g + 1) % N;
                        end
`else
                        m_ptr = (g + 1) % N;
`endif
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq[6];
        int lock_seq[5];
        int ch1_beats;
        logic [N-1:0] hs;

        exp_seq = '{0, 1, 2, 3, 0, 1};
`ifdef MUX_ARB_LOCK_EN
        lock_seq = '{1, 1, 1, 3, 0};
`else
        lock_seq = '{1, 3, 0, 1, 3};
`endif

        reset = 1'b1; reset3 = 1'b1;
        in_valid = '0; in_lock = '0; in_data = '0; out_ready = 1'b0;
        v3 = '0; d3 = {8'hA2, 8'hA1, 8'hA0};

        // Reset then idle.
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0; reset3 = 1'b0;

        // All four valid, full throughput.
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'(i) * 32'h11111111;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("rr_first_ready", in_ready, 4'b0001);
        check("rr_latency_valid", out_valid, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", out_valid, 1);
            check("rr_sel", out_sel, exp_seq[k]);
            check("rr_data", out_data, 32'(exp_seq[k]) * 32'h11111111);
        end
        in_valid = '0;
        tick();
        check("drain_valid", out_valid, 0);

        // Channel 2 alone with a downstream stall.
        in_valid = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        out_ready = 1'b0;
        #1;
        check("ch2_ready", in_ready, 4'b0100);
        tick();
        check("ch2_valid", out_valid, 1);
        check("ch2_data", out_data, 32'hDEADBEEF);
        check("ch2_sel", out_sel, 2);
        in_data[2*WIDTH +: WIDTH] = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 32'hDEADBEEF);
            check("stall_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", in_ready, 4'b0100);
        tick();
        check("replace_valid", out_valid, 1);
        check("replace_data", out_data, 32'hCAFEF00D);
        out_ready = 1'b0;
        in_valid = '0;

        // Reset while a beat is stalled in the output register.
        tick();
        check("held_before_rst", out_data, 32'hCAFEF00D);
        reset = 1'b1;
        tick();
        check("rst_drop_valid", out_valid, 0);
        check("rst_drop_data", out_data, 0);
        check("rst_drop_sel", out_sel, 0);
        reset = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("rst_ptr_zero", in_ready, 4'b0001);
        tick();
        check("post_rst_sel", out_sel, 0);

        // Lock scenario: ptr now 1, channels 0, 1 and 3 valid.
        in_valid = 4'b1011;
        in_lock = 4'b0010;
        ch1_beats = 0;
        #1;
        check("lock_first_ready", in_ready, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("lock_sel", out_sel, lock_seq[k]);
            if (lock_seq[k] == 1) ch1_beats++;
            in_lock[1] = (ch1_beats < 2);
        end
        in_valid = '0;
        in_lock = '0;
        tick();

        // N=3 wrap: drive ptr to 2, then alternate channels 2 and 0.
        v3 = 3'b010;
        tick();
        check("n3_sel_first", os3, 1);
        check("n3_data_first", od3, 8'hA1);
        v3 = 3'b101;
        #1;
        check("n3_ready_ptr2", rdy3, 3'b100);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("n3_valid", ov3, 1);
            check("n3_sel", os3, (k % 2 == 0) ? 2 : 0);
            check("n3_data", od3, (k % 2 == 0) ? 8'hA2 : 8'hA0);
        end
        v3 = '0;

        // Randomized traffic; sources hold a pending beat until accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !hs[i])) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_data[i*WIDTH +: WIDTH] = $urandom;
                    in_lock[i] = ($urandom_range(0, 3) == 0);
                end
            end
        end
        reset = 1'b0;
        in_valid = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
